hci_core_r_decoupler: RTL
=========================

// Module: hci_core_r_decoupler
// PURPOSE
// - Read-only TCDM response decoupler that sits between a streamer source's TCDM master port and the HCI interconnect.
// - Issues a read only when a response slot is guaranteed free, so a stalled stream consumer (lrdy low) never loses r_data.
// - Provides credit-based outstanding-read tracking and a FWFT response FIFO. Requests pass through unregistered.
// PARAMETERS
// - ADDR_WIDTH  32  TCDM byte-address width
// - DATA_WIDTH  32  TCDM read-data width
// - FIFO_DEPTH  4   response slots (>=2); also the max number of in-flight reads
// - CNT_W  $clog2(FIFO_DEPTH+1)  derived; occupancy/outstanding counter width (localparam)
// PORTS
// - clk_i            in   1           clock
// - rst_i            in   1           synchronous active-high reset
// - clear_i          in   1           synchronous soft clear, same effect as rst_i
// - tgt_req_i        in   1           read request from streamer source
// - tgt_add_i        in   ADDR_WIDTH  request byte address
// - tgt_gnt_o        out  1           grant to streamer source
// - tgt_lrdy_i       in   1           source/stream ready to take response
// - tgt_r_valid_o    out  1           response valid to source
// - tgt_r_data_o     out  DATA_WIDTH  response data to source
// - init_req_o       out  1           request to interconnect
// - init_add_o       out  ADDR_WIDTH  address to interconnect (= tgt_add_i)
// - init_wen_o       out  1           constant 1 (read)
// - init_gnt_i       in   1           interconnect grant
// - init_r_valid_i   in   1           interconnect response valid
// - init_r_data_i    in   DATA_WIDTH  interconnect response data
// - outstanding_o    out  CNT_W       reads granted but not yet responded
// - empty_o          out  1           FIFO empty and outstanding_o==0
// - err_o            out  1           sticky: response received with outstanding==0
// BEHAVIOUR
// - Reset/clear values: counters 0, FIFO empty, tgt_r_valid_o=0, tgt_r_data_o=0, err_o=0, empty_o=1.
// - credit_ok = (fifo_cnt + outstanding) < FIFO_DEPTH, computed from registered state only.
// - init_req_o = tgt_req_i & credit_ok & ~clear_i & ~rst_i. tgt_gnt_o = init_gnt_i & init_req_o.
// - Issue handshake = init_req_o & init_gnt_i: outstanding +1 next cycle.
// - init_r_valid_i with outstanding>0: push init_r_data_i into FIFO, outstanding -1.
// - Same-cycle issue and response: outstanding unchanged, FIFO pushed.
// - init_r_valid_i with outstanding==0: data dropped, err_o set. err_o stays set until rst_i or clear_i.
// - FIFO is FWFT: tgt_r_valid_o = ~fifo_empty, tgt_r_data_o = head entry.
// - Pop on tgt_r_valid_o & tgt_lrdy_i. Push and pop in the same cycle keeps fifo_cnt constant.
// - Response latency (no bypass): one cycle from init_r_valid_i to tgt_r_valid_o.
// - Push while full is impossible by credit invariant fifo_cnt + outstanding <= FIFO_DEPTH (bench asserts it).
// - Read/write pointers wrap modulo FIFO_DEPTH. Non-power-of-2 depth is supported via explicit compare-and-reset.
// - Reset or clear mid-operation drops FIFO contents and the outstanding count. Late responses then set err_o (documented, intended).
// - No combinational path from tgt_lrdy_i to init_req_o. Slot freed by a pop is usable from the next cycle.
// CONFIGURATION
// - HCI_R_DECOUPLER_BYPASS_EN defined:
//   - If FIFO is empty and tgt_lrdy_i=1, init_r_valid_i/init_r_data_i drive tgt_r_valid_o/tgt_r_data_o combinationally and nothing is pushed.
//   - Zero-cycle latency in this case.
//   - If tgt_lrdy_i=0 or the FIFO is non-empty, the response is pushed as in the default mode (ordering preserved).
// - HCI_R_DECOUPLER_BYPASS_EN undefined: every response goes through the FIFO (fixed 1-cycle latency). No path from init_r_* to tgt_r_*.
// TESTING
// - Reset, then 1 read to 0x100 granted at cycle 0, r_valid data 0xCAFE at cycle 1, lrdy=1
//   -> tgt_r_valid_o=1 data 0xCAFE at cycle 2 (bypass: cycle 1); outstanding_o back to 0.
// - DEPTH=4, lrdy=0, continuous req with gnt=1 and 1-cycle responses
//   -> exactly 4 grants, then init_req_o=0; after lrdy=1 the data pop in order and one new grant is issued per pop.
// - Issue and response in the same cycle for 10 cycles -> outstanding_o constant at 1; fifo_cnt+outstanding never exceeds 4.
// - Stray init_r_valid_i with outstanding_o=0 -> FIFO unchanged, err_o=1; err_o holds until clear_i pulse, then 0.
// - clear_i with 2 in FIFO and 1 outstanding -> next cycle tgt_r_valid_o=0, outstanding_o=0, empty_o=1;
//   init_req_o=0 during the clear cycle.
// - Random gnt/lrdy stalls over 1000 reads with an address-tagged data scoreboard -> no loss, no reorder, no duplication.

Source files
------------

// File: rtl/hci_core_r_decoupler.sv
// Read-only TCDM response decoupler between a streamer source master port and the HCI interconnect.
// Latency: request path combinational; response 1 cycle through the FIFO (0 cycles when bypassed).
// Backpressure: a read is issued only while a response slot is reserved, so tgt_lrdy_i low never loses data.
//
// Ports
//   clk_i, rst_i, clear_i        clock, synchronous active-high reset, synchronous soft clear (same effect)
//   tgt_req_i/tgt_add_i          read request and byte address from the streamer source
//   tgt_gnt_o                    grant back to the source (interconnect grant of a credited request)
//   tgt_lrdy_i                   source ready to accept a response
//   tgt_r_valid_o/tgt_r_data_o   response to the source (FWFT head of the response FIFO)
//   init_req_o/init_add_o        request to the interconnect, address passed through
//   init_wen_o                   tied to 1 (read only)
//   init_gnt_i                   interconnect grant
//   init_r_valid_i/init_r_data_i interconnect response
//   outstanding_o                reads granted but not yet answered
//   empty_o                      no buffered data and nothing in flight
//   err_o                        sticky: a response arrived with nothing in flight
//
// Optional feature macro: HCI_R_DECOUPLER_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty and tgt_lrdy_i is high is forwarded
//   combinationally to tgt_r_* and not stored. Otherwise every response is stored first.

module hci_core_r_decoupler #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clear_i,

    input  logic                                 tgt_req_i,
    input  logic [ADDR_WIDTH-1:0]                tgt_add_i,
    output logic                                 tgt_gnt_o,
    input  logic                                 tgt_lrdy_i,
    output logic                                 tgt_r_valid_o,
    output logic [DATA_WIDTH-1:0]                tgt_r_data_o,

    output logic                                 init_req_o,
    output logic [ADDR_WIDTH-1:0]                init_add_o,
    output logic                                 init_wen_o,
    input  logic                                 init_gnt_i,
    input  logic                                 init_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                init_r_data_i,

    output logic [$clog2(FIFO_DEPTH+1)-1:0]      outstanding_o,
    output logic                                 empty_o,
    output logic                                 err_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      outstanding;
    logic                  err_q;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic            soft_rst;
    logic [CNT_W:0]  credit_sum;
    logic            credit_ok;
    logic            fifo_empty;
    logic            issue;
    logic            resp_ok;
    logic            resp_stray;
    logic            bypass_take;
    logic            push;
    logic            pop;

    assign soft_rst   = rst_i | clear_i;
    assign fifo_empty = (fifo_cnt == '0);

    // Every buffered entry and every in-flight read holds one slot. Only registered
    // state feeds the credit, so tgt_lrdy_i never reaches init_req_o combinationally;
    // a slot freed by a pop becomes usable on the following cycle.
    assign credit_sum = {1'b0, fifo_cnt} + {1'b0, outstanding};
    assign credit_ok  = (credit_sum < CREDIT_MAX);

    assign init_req_o = tgt_req_i & credit_ok & ~soft_rst;
    assign init_add_o = tgt_add_i;
    assign init_wen_o = 1'b1;
    assign issue      = init_req_o & init_gnt_i;
    assign tgt_gnt_o  = issue;

    // A response with nothing in flight cannot belong to any read we issued
    // (typically a late answer to a read that was dropped by a clear): discard it.
    assign resp_ok    = init_r_valid_i & (outstanding != '0);
    assign resp_stray = init_r_valid_i & (outstanding == '0);

`ifdef HCI_R_DECOUPLER_BYPASS_EN
    // Forwarding only with an empty FIFO keeps responses in issue order.
    assign bypass_take = resp_ok & fifo_empty & tgt_lrdy_i;

    assign tgt_r_valid_o = ~fifo_empty | bypass_take;
    always_comb begin
        tgt_r_data_o = '0;
        if (!fifo_empty) begin
            tgt_r_data_o = fifo_mem[rd_ptr];
        end else if (bypass_take) begin
            tgt_r_data_o = init_r_data_i;
        end
    end
`else
    assign bypass_take = 1'b0;

    assign tgt_r_valid_o = ~fifo_empty;
    // Drive zero while empty so the data port is defined from reset onward
    // regardless of stale storage contents.
    assign tgt_r_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr];
`endif

    assign push = resp_ok & ~bypass_take;
    assign pop  = ~fifo_empty & tgt_lrdy_i;

    // ------------------------------------------------------------------
    // Response storage (contents need no reset; validity lives in fifo_cnt)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push && !soft_rst) begin
            fifo_mem[wr_ptr] <= init_r_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            // Explicit wrap so depths that are not a power of two work.
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end

            // Credit rule guarantees fifo_cnt + outstanding <= FIFO_DEPTH, so
            // neither counter can overflow and push never meets a full FIFO.
            fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp_ok);

            if (resp_stray) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = outstanding;
    assign empty_o       = fifo_empty & (outstanding == '0);
    assign err_o         = err_q;

endmodule
